simproc_dbg_ctrl: RTL and testbench
===================================

# simproc_dbg_ctrl

Host-side debug/loader controller sitting directly upstream of the simproc core and between the core and the program/data memory. Accepts a byte-stream command protocol (valid/ready) to write and read memory, set the PC, and run, single-step or stop the core. Owns the memory port while the core is halted and passes it through to the core otherwise.

## Interface

Parameters:
- ACK_BYTE, 8'hAA, response byte for a successful command without read data
- ERR_BYTE, 8'hEE, response byte for an illegal or rejected command

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  host command byte valid
- cmd_data  in  8  host command byte
- cmd_ready  out  1  controller accepts cmd_data this cycle
- rsp_valid  out  1  response byte valid
- rsp_data  out  8  response byte
- rsp_ready  in  1  host consumes response
- core_mem_addr, core_mem_din  in  8  core memory request
- core_mem_we  in  1  core write enable
- core_mem_dout  out  8  read data to core; always equals mem_dout
- mem_addr, mem_din  out  8  to memory (combinational read, synchronous write)
- mem_we  out  1  to memory
- mem_dout  in  8  from memory
- pc_set_val  out  8  to core
- pc_set_wr  out  1  to core
- run  out  1  to core
- halt, done  in  1  from core

## Operation

- Commands: 0x01 WRITE addr data; 0x02 READ addr; 0x03 SETPC val; 0x04 RUN; 0x05 STEP; 0x06 STOP. Any other opcode: discard the byte, respond ERR_BYTE.
- Every command produces exactly one response byte.
- States:
  - S_OP: accept opcode.
  - S_ARG1: accept first argument.
  - S_ARG2: accept second argument.
  - S_EXEC: one cycle.
  - S_WAIT_DONE.
  - S_WAIT_HALT.
  - S_RSP: hold rsp_valid until rsp_ready.
  - Transitions: S_OP to S_ARG1 for WRITE/READ/SETPC; S_ARG1 to S_ARG2 for WRITE; S_ARG1 to S_EXEC otherwise; S_OP to S_EXEC directly for RUN/STEP/STOP.
- Core-busy rule: the controller keeps a run_q flag. The core is idle when halt=1 and run_q=0.
  - WRITE, READ, SETPC and STEP while not idle: ERR_BYTE. No memory or PC side effect.
- WRITE: in S_EXEC, mem_addr=addr, mem_din=data, mem_we=1 for one cycle. Response is ACK_BYTE.
- READ: in S_EXEC, mem_addr=addr and mem_dout is captured. The response is the captured byte.
- SETPC: pc_set_val=val, pc_set_wr=1 for one cycle in S_EXEC. Response is ACK_BYTE.
- RUN: set run_q and respond ACK_BYTE. RUN while already running is idempotent and returns ACK_BYTE.
- STEP: run=1 for exactly the S_EXEC cycle. Then stay in S_WAIT_DONE until done=1, then go to S_RSP with ACK_BYTE.
- STOP: clear run_q and wait in S_WAIT_HALT until halt=1, then respond ACK_BYTE. If already halted, the wait lasts 0 extra cycles.
- run output = run_q | step_pulse.
- Memory mux: host drives mem_* only in S_EXEC of an accepted WRITE/READ. All other cycles pass core_mem_* through unchanged.

## Timing

- cmd_ready=1 combinationally in S_OP, S_ARG1 and S_ARG2 only. A byte transfers on cmd_valid & cmd_ready.
- rsp_valid=1 only in S_RSP. rsp_data is stable while rsp_valid=1. The response is consumed on rsp_valid & rsp_ready, then the FSM returns to S_OP the next cycle.
- Latency:
  - READ: the last argument byte accepted in cycle N gives S_EXEC at N+1 and rsp_valid at N+2.
  - WRITE and SETPC: same as READ.
  - RUN: the opcode accepted at N gives rsp_valid at N+2.
- STEP: run is high in the S_EXEC cycle E only. The core's done pulse arriving at cycle D gives rsp_valid at D+1.
- Reset values:
  - state=S_OP, run_q=0.
  - cmd_ready=1 after reset, 0 during rst.
  - rsp_valid=0, rsp_data=0.
  - pc_set_wr=0, pc_set_val=0, run=0.
  - mem_we follows core_mem_we (core drives 0 in reset).
- Reset mid-command discards partial bytes and any pending response, and drops run the following cycle.
- cmd_valid held during S_EXEC, S_WAIT_* or S_RSP is not consumed.

## Structure

- Shared package simproc_dbg_pkg holds:
  - cmd_op_t enum: CMD_WRITE=8'h01 .. CMD_STOP=8'h06.
  - dbg_state_t enum with the states above.
  - Default ACK/ERR constants.
- Single module, no sub-module required. The memory-port mux is inline combinational logic in this block.

## Test plan

- WRITE 0x01,0x10,0x5A then READ 0x02,0x10 -> two responses: 0xAA, then 0x5A. mem_we is high exactly one cycle with mem_addr=0x10.
- SETPC 0x03,0x20; STEP 0x05 with a core instruction at 0x20 -> pc_set_wr pulses with val 0x20. run is high exactly 1 cycle, and response 0xAA follows the core's done. halt=1 afterwards.
- RUN 0x04 then WRITE 0x01,0x00,0xFF -> 0xAA, then 0xEE. Memory at 0x00 is unchanged and the core mem port passes through.
- RUN, then STOP 0x06 -> run deasserts the cycle after STOP. The response 0xAA appears only after halt=1.
- Opcode 0x7F -> 0xEE. Holding rsp_ready=0 for 5 cycles keeps rsp_valid=1 with stable data, and cmd_ready=0.
- Assert rst mid-WRITE after the addr byte -> rsp_valid=0, cmd_ready=1 after reset, no write occurs. Next READ returns the old data.

Source files
------------

// File: rtl/simproc_dbg_pkg.sv
// Shared opcode, state and response definitions for the simproc debug/loader controller.
package simproc_dbg_pkg;

    typedef enum logic [7:0] {
        CMD_WRITE = 8'h01,
        CMD_READ  = 8'h02,
        CMD_SETPC = 8'h03,
        CMD_RUN   = 8'h04,
        CMD_STEP  = 8'h05,
        CMD_STOP  = 8'h06
    } cmd_op_t;

    typedef enum logic [2:0] {
        S_OP,
        S_ARG1,
        S_ARG2,
        S_EXEC,
        S_WAIT_DONE,
        S_WAIT_HALT,
        S_RSP
    } dbg_state_t;

    localparam logic [7:0] ACK_DEFAULT = 8'hAA;
    localparam logic [7:0] ERR_DEFAULT = 8'hEE;

    // Commands that touch memory, the PC or advance the core need it parked.
    function automatic logic needs_idle(input logic [7:0] op);
        return (op == CMD_WRITE) || (op == CMD_READ) || (op == CMD_SETPC) || (op == CMD_STEP);
    endfunction

endpackage

// File: rtl/simproc_dbg_ctrl.sv
// Byte-stream debug/loader controller: parses host commands, owns the memory port while
// the core is halted, and controls core run/step/stop plus PC loading.
module simproc_dbg_ctrl
    import simproc_dbg_pkg::*;
#(
    parameter logic [7:0] ACK_BYTE = ACK_DEFAULT,
    parameter logic [7:0] ERR_BYTE = ERR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       rsp_ready,
    input  logic [7:0] core_mem_addr,
    input  logic [7:0] core_mem_din,
    input  logic       core_mem_we,
    output logic [7:0] core_mem_dout,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       mem_we,
    input  logic [7:0] mem_dout,
    output logic [7:0] pc_set_val,
    output logic       pc_set_wr,
    output logic       run,
    input  logic       halt,
    input  logic       done
);

    dbg_state_t state;
    logic [7:0] op_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] rsp_q;
    logic       run_q;

    logic idle;
    logic exec_ok;
    logic host_mem;
    logic step_pulse;

    assign idle     = halt & ~run_q;
    assign exec_ok  = (state == S_EXEC) & idle & ~rst;
    assign host_mem = exec_ok & ((op_q == CMD_WRITE) | (op_q == CMD_READ));

    assign mem_addr      = host_mem ? addr_q : core_mem_addr;
    assign mem_din       = host_mem ? data_q : core_mem_din;
    assign mem_we        = host_mem ? (op_q == CMD_WRITE) : core_mem_we;
    assign core_mem_dout = mem_dout;

    assign pc_set_wr  = exec_ok & (op_q == CMD_SETPC);
    assign step_pulse = exec_ok & (op_q == CMD_STEP);
    assign run        = run_q | step_pulse;

    assign cmd_ready = ~rst & ((state == S_OP) | (state == S_ARG1) | (state == S_ARG2));
    assign rsp_valid = (state == S_RSP);
    assign rsp_data  = rsp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_OP;
            run_q      <= 1'b0;
            op_q       <= 8'h00;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            rsp_q      <= 8'h00;
            pc_set_val <= 8'h00;
        end else begin
            case (state)
                S_OP: begin
                    if (cmd_valid) begin
                        op_q <= cmd_data;
                        case (cmd_data)
                            CMD_WRITE, CMD_READ, CMD_SETPC: state <= S_ARG1;
                            CMD_RUN, CMD_STEP, CMD_STOP:    state <= S_EXEC;
                            default: begin
                                rsp_q <= ERR_BYTE;
                                state <= S_RSP;
                            end
                        endcase
                    end
                end
                S_ARG1: begin
                    if (cmd_valid) begin
                        addr_q <= cmd_data;
                        if (op_q == CMD_SETPC)
                            pc_set_val <= cmd_data;
                        state <= (op_q == CMD_WRITE) ? S_ARG2 : S_EXEC;
                    end
                end
                S_ARG2: begin
                    if (cmd_valid) begin
                        data_q <= cmd_data;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (needs_idle(op_q) && !idle) begin
                        rsp_q <= ERR_BYTE;
                        state <= S_RSP;
                    end else begin
                        case (op_q)
                            CMD_READ: begin
                                rsp_q <= mem_dout;
                                state <= S_RSP;
                            end
                            CMD_RUN: begin
                                run_q <= 1'b1;
                                rsp_q <= ACK_BYTE;
                                state <= S_RSP;
                            end
                            CMD_STEP: state <= S_WAIT_DONE;
                            CMD_STOP: begin
                                run_q <= 1'b0;
                                if (halt) begin
                                    rsp_q <= ACK_BYTE;
                                    state <= S_RSP;
                                end else begin
                                    state <= S_WAIT_HALT;
                                end
                            end
                            default: begin
                                rsp_q <= ACK_BYTE;
                                state <= S_RSP;
                            end
                        endcase
                    end
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        rsp_q <= ACK_BYTE;
                        state <= S_RSP;
                    end
                end
                S_WAIT_HALT: begin
                    if (halt) begin
                        rsp_q <= ACK_BYTE;
                        state <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready)
                        state <= S_OP;
                end
                default: state <= S_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_simproc_dbg_ctrl.sv
// Bench for simproc_dbg_ctrl: memory and core models, a command-level reference model
// compared every cycle, directed literal scenarios and a randomized byte stream.
module tb_simproc_dbg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ready;
    logic [7:0] core_mem_addr, core_mem_din, core_mem_dout;
    logic       core_mem_we;
    logic [7:0] mem_addr, mem_din, mem_dout;
    logic       mem_we;
    logic [7:0] pc_set_val;
    logic       pc_set_wr, run, halt, done;

    always #5 clk = ~clk;

    simproc_dbg_ctrl #(.ACK_BYTE(8'hAA), .ERR_BYTE(8'hEE)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .core_mem_addr(core_mem_addr), .core_mem_din(core_mem_din),
        .core_mem_we(core_mem_we), .core_mem_dout(core_mem_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .pc_set_val(pc_set_val), .pc_set_wr(pc_set_wr), .run(run),
        .halt(halt), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Physical memory: combinational read, write sampled mid-cycle and committed at the edge.
    logic [7:0] mem [256];
    assign mem_dout = mem[mem_addr];

    initial begin
        logic       s_we;
        logic [7:0] s_a, s_d;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        forever begin
            @(negedge clk);
            s_we = mem_we; s_a = mem_addr; s_d = mem_din;
            @(posedge clk);
            if (s_we === 1'b1) mem[s_a] = s_d;
        end
    end

    // Core model: each instruction takes 3 cycles, done on the last; core writes only >= 0x80.
    logic [1:0] busy;
    logic       we_rnd;
    assign done        = (busy == 2'd1);
    assign core_mem_we = (busy != 2'd0) & we_rnd;

    initial begin
        logic run_s, rst_s;
        busy = 2'd0; halt = 1'b1; we_rnd = 1'b0;
        core_mem_addr = 8'h80; core_mem_din = 8'h00;
        run_s = 1'b0; rst_s = 1'b1;
        forever begin
            @(posedge clk);
            if (rst_s) begin
                busy <= 2'd0;
                halt <= 1'b1;
            end else begin
                if (run_s && busy == 2'd0) busy <= 2'd3;
                else if (busy != 2'd0)     busy <= busy - 2'd1;
                if (run_s)                 halt <= 1'b0;
                else if (busy <= 2'd1)     halt <= 1'b1;
            end
            core_mem_addr <= 8'h80 | 8'($urandom);
            core_mem_din  <= 8'($urandom);
            we_rnd        <= 1'($urandom);
            @(negedge clk);
            run_s = (run === 1'b1);
            rst_s = rst;
        end
    end

    // Reference model: one command at a time as a byte list, then exec, wait and response.
    logic [7:0] cmd_q[$];
    bit         exec_now, wait_d, wait_h, rsp_pend, m_run;
    logic [7:0] rsp_exp;
    logic [7:0] ref_mem [256];
    int         we10_cnt = 0, run_cnt = 0, pcwr_cnt = 0;
    logic [7:0] pcval_last = 8'h00;

    function automatic int cmd_len(input logic [7:0] op);
        case (op)
            8'h01:               return 3;
            8'h02, 8'h03:        return 2;
            8'h04, 8'h05, 8'h06: return 1;
            default:             return 0;
        endcase
    endfunction

    initial begin
        logic       idle, host, e_we, e_run, e_pcw, accepting;
        logic [7:0] op, e_addr, e_din;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
        exec_now = 0; wait_d = 0; wait_h = 0; rsp_pend = 0; m_run = 0; rsp_exp = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1 && mem_addr == 8'h10) we10_cnt++;
            if (run === 1'b1) run_cnt++;
            if (pc_set_wr === 1'b1) begin pcwr_cnt++; pcval_last = pc_set_val; end
            if (rst) begin
                chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
                cmd_q.delete();
                exec_now = 0; wait_d = 0; wait_h = 0; rsp_pend = 0; m_run = 0;
            end else begin
                op        = (cmd_q.size() > 0) ? cmd_q[0] : 8'h00;
                idle      = halt && !m_run;
                accepting = !exec_now && !wait_d && !wait_h && !rsp_pend;
                host      = exec_now && idle && (op == 8'h01 || op == 8'h02);
                e_we      = host ? (op == 8'h01) : core_mem_we;
                e_addr    = host ? cmd_q[1] : core_mem_addr;
                e_din     = host ? ((op == 8'h01) ? cmd_q[2] : 8'h00) : core_mem_din;
                e_pcw     = exec_now && idle && op == 8'h03;
                e_run     = m_run || (exec_now && idle && op == 8'h05);

                chk("m_cmd_ready", 32'(cmd_ready), 32'(accepting));
                chk("m_rsp_valid", 32'(rsp_valid), 32'(rsp_pend));
                if (rsp_pend) chk("m_rsp_data", 32'(rsp_data), 32'(rsp_exp));
                chk("m_mem_we", 32'(mem_we), 32'(e_we));
                chk("m_mem_addr", 32'(mem_addr), 32'(e_addr));
                if (e_we) chk("m_mem_din", 32'(mem_din), 32'(e_din));
                chk("m_run", 32'(run), 32'(e_run));
                chk("m_pc_set_wr", 32'(pc_set_wr), 32'(e_pcw));
                if (e_pcw) chk("m_pc_set_val", 32'(pc_set_val), 32'(cmd_q[1]));
                chk("m_core_mem_dout", 32'(core_mem_dout), 32'(mem_dout));

                if (e_we) ref_mem[e_addr] = e_din;

                if (rsp_pend) begin
                    if (rsp_ready) begin rsp_pend = 0; cmd_q.delete(); end
                end else if (wait_d) begin
                    if (done) begin wait_d = 0; rsp_pend = 1; rsp_exp = 8'hAA; end
                end else if (wait_h) begin
                    if (halt) begin wait_h = 0; rsp_pend = 1; rsp_exp = 8'hAA; end
                end else if (exec_now) begin
                    exec_now = 0;
                    if ((op inside {8'h01, 8'h02, 8'h03, 8'h05}) && !idle) begin
                        rsp_pend = 1; rsp_exp = 8'hEE;
                    end else begin
                        case (op)
                            8'h02: begin rsp_pend = 1; rsp_exp = ref_mem[cmd_q[1]]; end
                            8'h04: begin m_run = 1; rsp_pend = 1; rsp_exp = 8'hAA; end
                            8'h05: wait_d = 1;
                            8'h06: begin
                                m_run = 0;
                                if (halt) begin rsp_pend = 1; rsp_exp = 8'hAA; end
                                else wait_h = 1;
                            end
                            default: begin rsp_pend = 1; rsp_exp = 8'hAA; end
                        endcase
                    end
                end else if (accepting && cmd_valid) begin
                    cmd_q.push_back(cmd_data);
                    if (cmd_len(cmd_q[0]) == 0) begin rsp_pend = 1; rsp_exp = 8'hEE; end
                    else if (cmd_q.size() == cmd_len(cmd_q[0])) exec_now = 1;
                end
            end
        end
    end

    // Directed stimulus helpers; inputs change 1 time unit after the rising edge.
    logic rsp_halt, rsp_run;

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic acc;
        n = 0; acc = 1'b0;
        cmd_valid = 1'b1; cmd_data = b;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = cmd_ready;
            n++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic get_rsp(input logic [7:0] exp, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        if (rsp_valid !== 1'b1) chk({nm, "_timeout"}, 32'(rsp_valid), 32'd1);
        else chk(nm, 32'(rsp_data), 32'(exp));
        rsp_halt = halt;
        rsp_run  = run;
        @(posedge clk); #1;
    endtask

    initial begin
        int r, snap_we, snap_run, snap_pc;
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'h00);
        chk("reset_run", 32'(run), 32'd0);
        chk("reset_pc_set_wr", 32'(pc_set_wr), 32'd0);
        chk("reset_pc_set_val", 32'(pc_set_val), 32'h00);
        chk("reset_mem_we", 32'(mem_we), 32'(core_mem_we));
        @(posedge clk); #1;

        // WRITE then READ back
        snap_we = we10_cnt;
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h5A);
        get_rsp(8'hAA, "write_ack");
        send_byte(8'h02); send_byte(8'h10);
        get_rsp(8'h5A, "read_back");
        chk("write_we_once", 32'(we10_cnt - snap_we), 32'd1);

        // SETPC then single STEP
        snap_pc = pcwr_cnt;
        send_byte(8'h03); send_byte(8'h20);
        get_rsp(8'hAA, "setpc_ack");
        chk("setpc_pulse_once", 32'(pcwr_cnt - snap_pc), 32'd1);
        chk("setpc_val", 32'(pcval_last), 32'h20);
        snap_run = run_cnt;
        send_byte(8'h05);
        get_rsp(8'hAA, "step_ack");
        chk("step_run_one_cycle", 32'(run_cnt - snap_run), 32'd1);
        chk("step_halt_after", 32'(rsp_halt), 32'd1);

        // RUN, rejected WRITE while running, then STOP
        send_byte(8'h04);
        get_rsp(8'hAA, "run_ack");
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hFF);
        get_rsp(8'hEE, "write_busy_err");
        send_byte(8'h06);
        get_rsp(8'hAA, "stop_ack");
        chk("stop_halt_seen", 32'(rsp_halt), 32'd1);
        chk("stop_run_low", 32'(rsp_run), 32'd0);
        send_byte(8'h02); send_byte(8'h00);
        get_rsp(8'h0B, "mem0_unchanged");

        // Illegal opcode with back-pressured response
        rsp_ready = 1'b0;
        send_byte(8'h7F);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_data", 32'(rsp_data), 32'hEE);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        get_rsp(8'hEE, "illegal_err");

        // Reset in the middle of a WRITE
        snap_we = we10_cnt;
        send_byte(8'h01); send_byte(8'h10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        send_byte(8'h02); send_byte(8'h10);
        get_rsp(8'h5A, "midrst_read_old");
        chk("midrst_no_write", 32'(we10_cnt - snap_we), 32'd0);

        // Randomized byte stream, checked by the reference model every cycle
        for (int i = 0; i < 3000; i++) begin
            r         = $urandom_range(0, 9);
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_data  = (r < 6) ? 8'($urandom_range(1, 6)) : ((r < 9) ? 8'($urandom) : 8'h7F);
            rsp_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 399) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
